n_outport_ctrl: RTL and testbench
=================================

N_OUTPORT_CTRL -- requirements
Module: n_outport_ctrl

Interface
REQ-001 SHALL have parameter FLIT_W, default 32, meaning flit width in bits.
REQ-002 SHALL have parameter CREDITS, default 4, meaning downstream buffer depth (credit counter max).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports rrp_n_priority_s_i/_w_i/_e_i/_l_i, input, 1 each, one-hot arbiter winner for the north output.
REQ-006 SHALL have port rrp_n_priority_to_cs_i, input, 3, winner code: 001 S, 010 W, 011 E, 100 L; other codes are invalid.
REQ-007 SHALL have ports s_/w_/e_/l_flit_i, input, FLIT_W each, head-of-queue flit per input port.
REQ-008 SHALL have ports s_/w_/e_/l_flit_valid_i, input, 1 each, head flit present.
REQ-009 SHALL have ports s_/w_/e_/l_flit_tail_i, input, 1 each, head flit is the packet tail.
REQ-010 SHALL have ports s_/w_/e_/l_flit_pop_o, output, 1 each, dequeue strobe to that input queue.
REQ-011 SHALL have port n_credit_i, input, 1, one-cycle credit return from downstream.
REQ-012 SHALL have port n_flit_o, output, FLIT_W, registered north output flit.
REQ-013 SHALL have port n_flit_valid_o, output, 1, n_flit_o valid this cycle.
REQ-014 SHALL have port cs_sel_o, output, 3, locked crossbar select (same encoding as REQ-006; 000 when idle).
REQ-015 SHALL have port rr_register_change_order_o, output, 1, one-cycle pulse that rotates the arbiter's round-robin order.
REQ-016 SHALL have port busy_o, output, 1, high while a packet holds the output.

Function
REQ-017 SHALL implement FSM with states IDLE and XFER.
REQ-018 IDLE: when exactly one rrp_n_priority_*_i is high and its code matches rrp_n_priority_to_cs_i, SHALL latch that source into cs_sel_o and enter XFER on the next edge.
REQ-019 IDLE: zero winners, more than one winner, or a one-hot/code mismatch SHALL be ignored (remain IDLE, no pops).
REQ-020 XFER: arbiter inputs SHALL be ignored; the grant stays locked until the tail flit is sent.
REQ-021 XFER: a send occurs in a cycle when the locked source's flit_valid_i=1 and credit count > 0.
REQ-022 On a send: the locked source's flit_pop_o SHALL be high that same cycle (combinational); n_flit_o/n_flit_valid_o SHALL present that flit on the next cycle (latency 1).
REQ-023 Pops on non-locked sources SHALL never assert; at most one pop per cycle.
REQ-024 Sending a flit with tail=1 SHALL pulse rr_register_change_order_o for exactly that cycle and return to IDLE on the next edge (single-flit packet: head=tail, allowed).
REQ-025 Credit counter, width clog2(CREDITS+1): send decrements; n_credit_i increments; both in the same cycle leave it unchanged.
REQ-026 Credit count SHALL never exceed CREDITS (an increment at max is dropped) and SHALL never underflow (no send at 0).
REQ-027 n_flit_valid_o SHALL be 0 in any cycle following a cycle with no send; n_flit_o holds its last value.
REQ-028 busy_o SHALL be 1 exactly in XFER.
REQ-029 From IDLE a new grant SHALL be accepted no earlier than the cycle after the tail's return to IDLE (one idle bubble minimum between packets).

Reset
REQ-030 When reset=1 at a clock edge: state=IDLE, credit=CREDITS, cs_sel_o=000, n_flit_valid_o=0, n_flit_o=0, rr_register_change_order_o=0, busy_o=0, all pops 0.
REQ-031 Reset mid-packet SHALL abandon the packet with no change_order pulse; combinational pops SHALL be 0 while reset=1.

Verification
REQ-032 Winner S (code 001), 3-flit packet A,B,C(tail), credits 4 -> pops cycles 1-3, n_flit_o A,B,C cycles 2-4, change_order pulse in cycle 3, credit=1.
REQ-033 CREDITS=4, 6-flit packet, no credit return -> 4 flits sent, stall with busy_o=1; one n_credit_i pulse -> exactly one more flit sent.
REQ-034 Credit return and send in the same cycle at credit=2 -> credit stays 2; n_credit_i at credit=4 -> stays 4.
REQ-035 Locked W; arbiter switches to E mid-packet -> only w_flit_pop_o fires, cs_sel_o stays 010 until the tail.
REQ-036 Priority s and w both high, or s high with code 011 -> stays IDLE, no pops, cs_sel_o=000.
REQ-037 Reset asserted after 2 of 4 flits -> next cycle all outputs at reset values, credit=4, no change_order pulse.

Source files
------------

// File: rtl/n_outport_ctrl.sv
// rtl/n_outport_ctrl.sv - north output port controller: grant lock, credit flow control, flit register
//
// Purpose:
//   Takes the one-hot winner from the north round-robin arbiter and locks the
//   crossbar onto that source until the packet tail has been sent. Flits are
//   forwarded only while downstream credits remain. Each forwarded flit is
//   popped from its input queue in the same cycle and appears on the
//   registered output one cycle later.
//
// Ports:
//   clk, reset                     single clock, synchronous active-high reset
//   rrp_n_priority_{s,w,e,l}_i     one-hot arbiter winner
//   rrp_n_priority_to_cs_i         winner code (001 S, 010 W, 011 E, 100 L)
//   {s,w,e,l}_flit_i/_valid_i/_tail_i   head-of-queue flit per input
//   {s,w,e,l}_flit_pop_o           dequeue strobe (combinational)
//   n_credit_i                     one-cycle credit return from downstream
//   n_flit_o, n_flit_valid_o       registered north output flit
//   cs_sel_o                       locked crossbar select, 000 when idle
//   rr_register_change_order_o     pulse on tail send, rotates arbiter order
//   busy_o                         high while a packet holds the output

module n_outport_ctrl #(
  parameter int FLIT_W  = 32,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rrp_n_priority_s_i,
  input  logic              rrp_n_priority_w_i,
  input  logic              rrp_n_priority_e_i,
  input  logic              rrp_n_priority_l_i,
  input  logic [2:0]        rrp_n_priority_to_cs_i,
  input  logic [FLIT_W-1:0] s_flit_i,
  input  logic [FLIT_W-1:0] w_flit_i,
  input  logic [FLIT_W-1:0] e_flit_i,
  input  logic [FLIT_W-1:0] l_flit_i,
  input  logic              s_flit_valid_i,
  input  logic              w_flit_valid_i,
  input  logic              e_flit_valid_i,
  input  logic              l_flit_valid_i,
  input  logic              s_flit_tail_i,
  input  logic              w_flit_tail_i,
  input  logic              e_flit_tail_i,
  input  logic              l_flit_tail_i,
  output logic              s_flit_pop_o,
  output logic              w_flit_pop_o,
  output logic              e_flit_pop_o,
  output logic              l_flit_pop_o,
  input  logic              n_credit_i,
  output logic [FLIT_W-1:0] n_flit_o,
  output logic              n_flit_valid_o,
  output logic [2:0]        cs_sel_o,
  output logic              rr_register_change_order_o,
  output logic              busy_o
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_S    = 3'b001;
  localparam logic [2:0] SEL_W    = 3'b010;
  localparam logic [2:0] SEL_E    = 3'b011;
  localparam logic [2:0] SEL_L    = 3'b100;

  logic [0:0]        state;
  logic [2:0]        cs_sel;
  logic [CW-1:0]     credit;
  logic [FLIT_W-1:0] flit_q;
  logic              flit_valid_q;

  logic [3:0]        winner;
  logic [2:0]        winner_code;
  logic              grant_ok;

  logic [FLIT_W-1:0] src_flit;
  logic              src_valid;
  logic              src_tail;
  logic              send;

  // Winner decode: the one-hot vector must name exactly one source and agree
  // with the arbiter's code; anything else is treated as no request.
  assign winner = {rrp_n_priority_l_i, rrp_n_priority_e_i,
                   rrp_n_priority_w_i, rrp_n_priority_s_i};

  always_comb begin
    winner_code = SEL_NONE;
    case (winner)
      4'b0001: winner_code = SEL_S;
      4'b0010: winner_code = SEL_W;
      4'b0100: winner_code = SEL_E;
      4'b1000: winner_code = SEL_L;
      default: winner_code = SEL_NONE;
    endcase
  end

  assign grant_ok = (winner_code != SEL_NONE) && (winner_code == rrp_n_priority_to_cs_i);

  // Locked-source mux; an unlocked select yields an empty source so that no
  // send can happen outside XFER.
  always_comb begin
    src_flit  = '0;
    src_valid = 1'b0;
    src_tail  = 1'b0;
    case (cs_sel)
      SEL_S: begin src_flit = s_flit_i; src_valid = s_flit_valid_i; src_tail = s_flit_tail_i; end
      SEL_W: begin src_flit = w_flit_i; src_valid = w_flit_valid_i; src_tail = w_flit_tail_i; end
      SEL_E: begin src_flit = e_flit_i; src_valid = e_flit_valid_i; src_tail = e_flit_tail_i; end
      SEL_L: begin src_flit = l_flit_i; src_valid = l_flit_valid_i; src_tail = l_flit_tail_i; end
      default: begin src_flit = '0; src_valid = 1'b0; src_tail = 1'b0; end
    endcase
  end

  // Reset gates the send so pops and the change-order pulse stay low while
  // a packet is being abandoned.
  assign send = (state == XFER) && src_valid && (credit != '0) && !reset;

  assign s_flit_pop_o = send && (cs_sel == SEL_S);
  assign w_flit_pop_o = send && (cs_sel == SEL_W);
  assign e_flit_pop_o = send && (cs_sel == SEL_E);
  assign l_flit_pop_o = send && (cs_sel == SEL_L);

  assign rr_register_change_order_o = send && src_tail;

  assign busy_o         = (state == XFER);
  assign cs_sel_o       = cs_sel;
  assign n_flit_o       = flit_q;
  assign n_flit_valid_o = flit_valid_q;

  // Grant FSM. The tail send drops back to IDLE; a new grant is only looked
  // at from IDLE, which leaves at least one idle cycle between packets.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cs_sel <= SEL_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            state  <= XFER;
            cs_sel <= rrp_n_priority_to_cs_i;
          end
        end
        XFER: begin
          if (send && src_tail) begin
            state  <= IDLE;
            cs_sel <= SEL_NONE;
          end
        end
        default: begin
          state  <= IDLE;
          cs_sel <= SEL_NONE;
        end
      endcase
    end
  end

  // Credit counter. A send already implies credit > 0, so send plus return
  // nets to zero even at the maximum; a lone return at the maximum is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit <= CREDIT_MAX;
    end else if (send && n_credit_i) begin
      credit <= credit;
    end else if (send) begin
      credit <= credit - CW'(1);
    end else if (n_credit_i && (credit != CREDIT_MAX)) begin
      credit <= credit + CW'(1);
    end
  end

  // Output register: valid follows the send one cycle later; the flit data
  // holds its last value when nothing is sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
    end else begin
      flit_valid_q <= send;
      if (send) begin
        flit_q <= src_flit;
      end
    end
  end

endmodule

// File: tb/tb_n_outport_ctrl.sv
// tb/tb_n_outport_ctrl.sv - self-checking bench for n_outport_ctrl
module tb_n_outport_ctrl;
  localparam int FW = 32;
  localparam int CR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [3:0]    pr;
  logic [2:0]    code;
  logic          crd;
  logic [FW-1:0] hf [4];
  logic [3:0]    hv, ht;
  logic [3:0]    dpop;
  logic [FW-1:0] n_flit;
  logic          n_valid, co, busy;
  logic [2:0]    cs;

  n_outport_ctrl #(.FLIT_W(FW), .CREDITS(CR)) dut (
    .clk(clk), .reset(reset),
    .rrp_n_priority_s_i(pr[0]), .rrp_n_priority_w_i(pr[1]),
    .rrp_n_priority_e_i(pr[2]), .rrp_n_priority_l_i(pr[3]),
    .rrp_n_priority_to_cs_i(code),
    .s_flit_i(hf[0]), .w_flit_i(hf[1]), .e_flit_i(hf[2]), .l_flit_i(hf[3]),
    .s_flit_valid_i(hv[0]), .w_flit_valid_i(hv[1]), .e_flit_valid_i(hv[2]), .l_flit_valid_i(hv[3]),
    .s_flit_tail_i(ht[0]), .w_flit_tail_i(ht[1]), .e_flit_tail_i(ht[2]), .l_flit_tail_i(ht[3]),
    .s_flit_pop_o(dpop[0]), .w_flit_pop_o(dpop[1]), .e_flit_pop_o(dpop[2]), .l_flit_pop_o(dpop[3]),
    .n_credit_i(crd),
    .n_flit_o(n_flit), .n_flit_valid_o(n_valid),
    .cs_sel_o(cs), .rr_register_change_order_o(co), .busy_o(busy)
  );

  // Per-port input queues
  logic [FW-1:0] mem [4][32];
  logic          tl  [4][32];
  int            len [4];
  int            ptr [4];

  // Packet-level model: which source holds the output, how many credits remain
  bit            m_busy;
  int            m_src;
  int            m_credit;
  logic [FW-1:0] m_flit;
  bit            m_valid;
  logic [3:0]    e_pop;
  bit            e_co;

  int n_cmp = 0;
  int n_bad = 0;
  int pop_cnt [4];
  int co_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int p, input int n, input logic [FW-1:0] base);
    for (int k = 0; k < n; k++) begin
      mem[p][len[p]] = base + FW'(k);
      tl[p][len[p]]  = (k == n - 1);
      len[p]++;
    end
  endtask

  task automatic drive_heads();
    for (int p = 0; p < 4; p++) begin
      hv[p] = (ptr[p] < len[p]);
      hf[p] = hv[p] ? mem[p][ptr[p]] : '0;
      ht[p] = hv[p] ? tl[p][ptr[p]] : 1'b0;
    end
  endtask

  task automatic clr();
    for (int p = 0; p < 4; p++) pop_cnt[p] = 0;
    co_cnt = 0;
  endtask

  task automatic model_comb();
    int i;
    e_pop = '0;
    e_co  = 1'b0;
    if (!reset && m_busy) begin
      i = m_src - 1;
      if (hv[i] && m_credit > 0) begin
        e_pop[i] = 1'b1;
        e_co     = ht[i];
      end
    end
  endtask

  task automatic model_seq();
    int  i;
    int  nw;
    bit  snd;
    if (reset) begin
      m_busy = 0; m_src = 0; m_credit = CR; m_flit = '0; m_valid = 0;
    end else begin
      snd = (e_pop != 0);
      i = m_src - 1;
      m_valid = snd;
      if (snd) m_flit = hf[i];
      m_credit = m_credit - (snd ? 1 : 0) + (crd ? 1 : 0);
      if (m_credit > CR) m_credit = CR;
      if (m_busy) begin
        if (snd && ht[i]) begin m_busy = 0; m_src = 0; end
      end else begin
        nw = int'(pr[0]) + int'(pr[1]) + int'(pr[2]) + int'(pr[3]);
        if (nw == 1)
          for (int k = 0; k < 4; k++)
            if (pr[k] && int'(code) == k + 1) begin m_busy = 1; m_src = k + 1; end
      end
      if (snd) ptr[i]++;
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, compare, then advance the model
  task automatic cyc(input logic [3:0] p, input logic [2:0] c, input logic cr, input logic r);
    logic [2:0] exp_cs;
    reset = r; pr = p; code = c; crd = cr;
    drive_heads();
    #1;
    model_comb();
    exp_cs = 3'(m_src);
    chk("pop", dpop, e_pop);
    chk("change_order", co, e_co);
    chk("n_flit_valid", n_valid, m_valid);
    chk("n_flit", n_flit, m_flit);
    chk("cs_sel", cs, exp_cs);
    chk("busy", busy, m_busy);
    for (int k = 0; k < 4; k++) pop_cnt[k] += int'(dpop[k]);
    co_cnt += int'(co);
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(4'b0000, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic refill(input int n);
    repeat (n) cyc(4'b0000, 3'b000, 1'b1, 1'b0);
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin len[p] = 0; ptr[p] = 0; end
    reset = 1'b1; pr = '0; code = '0; crd = 1'b0;
    drive_heads();
    @(posedge clk); @(posedge clk); @(negedge clk);
    m_busy = 0; m_src = 0; m_credit = CR; m_flit = '0; m_valid = 0;
    clr();

    // Reset state
    cyc(4'b0000, 3'b000, 1'b0, 1'b1);
    chk("rst_busy", busy, 0);
    chk("rst_cs", cs, 3'b000);
    chk("rst_valid", n_valid, 0);
    chk("rst_flit", n_flit, 0);

    // Winner S, 3-flit packet A,B,C
    load(0, 3, 32'hA);
    clr();
    cyc(4'b0001, 3'b001, 1'b0, 1'b0);
    cyc(4'b0000, 3'b000, 1'b0, 1'b0);
    chk("t1_flit_a", n_flit, 32'hA);
    cyc(4'b0000, 3'b000, 1'b0, 1'b0);
    chk("t1_flit_b", n_flit, 32'hB);
    chk("t1_co_before_tail", co_cnt, 0);
    cyc(4'b0000, 3'b000, 1'b0, 1'b0);
    chk("t1_flit_c", n_flit, 32'hC);
    chk("t1_valid_c", n_valid, 1);
    chk("t1_co", co_cnt, 1);
    chk("t1_pops", pop_cnt[0], 3);
    chk("t1_credit", m_credit, 1);
    chk("t1_busy_after", busy, 0);
    refill(3);
    chk("t1_refill", m_credit, 4);

    // Invalid grants: two winners, code mismatch, invalid code, no winner
    load(0, 2, 32'h100);
    clr();
    cyc(4'b0011, 3'b001, 1'b0, 1'b0);
    cyc(4'b0001, 3'b011, 1'b0, 1'b0);
    cyc(4'b0001, 3'b111, 1'b0, 1'b0);
    cyc(4'b0000, 3'b001, 1'b0, 1'b0);
    chk("t2_busy", busy, 0);
    chk("t2_cs", cs, 3'b000);
    chk("t2_pops", pop_cnt[0], 0);
    cyc(4'b0001, 3'b001, 1'b0, 1'b0);
    idle(3);
    chk("t2_flush_pops", pop_cnt[0], 2);
    refill(2);

    // 6-flit packet with only 4 credits
    load(3, 6, 32'h300);
    clr();
    cyc(4'b1000, 3'b100, 1'b0, 1'b0);
    idle(8);
    chk("t3_stall_pops", pop_cnt[3], 4);
    chk("t3_stall_busy", busy, 1);
    cyc(4'b0000, 3'b000, 1'b1, 1'b0);
    idle(3);
    chk("t3_one_more", pop_cnt[3], 5);
    chk("t3_still_busy", busy, 1);
    refill(3);
    chk("t3_done_pops", pop_cnt[3], 6);
    chk("t3_done_busy", busy, 0);
    refill(4);
    chk("t3_credit_capped", m_credit, 4);

    // Send and credit return in the same cycle at credit 2
    load(2, 4, 32'h200);
    clr();
    cyc(4'b0100, 3'b011, 1'b0, 1'b0);
    idle(2);
    chk("t4_credit_2", m_credit, 2);
    cyc(4'b0000, 3'b000, 1'b1, 1'b0);
    chk("t4_credit_held", m_credit, 2);
    idle(1);
    chk("t4_pops", pop_cnt[2], 4);
    chk("t4_credit_1", m_credit, 1);
    load(0, 3, 32'h400);
    clr();
    cyc(4'b0001, 3'b001, 1'b0, 1'b0);
    idle(4);
    chk("t4_last_credit", pop_cnt[0], 1);
    chk("t4_stall_busy", busy, 1);
    refill(6);
    chk("t4_finish_pops", pop_cnt[0], 3);
    chk("t4_finish_busy", busy, 0);

    // Locked W while the arbiter switches to E
    load(1, 3, 32'h500);
    load(2, 3, 32'h600);
    clr();
    cyc(4'b0010, 3'b010, 1'b0, 1'b0);
    repeat (3) cyc(4'b0100, 3'b011, 1'b1, 1'b0);
    chk("t5_w_pops", pop_cnt[1], 3);
    chk("t5_e_pops", pop_cnt[2], 0);
    chk("t5_bubble_busy", busy, 0);
    cyc(4'b0100, 3'b011, 1'b0, 1'b0);
    idle(3);
    chk("t5_e_after", pop_cnt[2], 3);
    chk("t5_e_last", n_flit, 32'h602);
    refill(3);

    // Reset after 2 of 4 flits
    load(0, 4, 32'h700);
    clr();
    cyc(4'b0001, 3'b001, 1'b0, 1'b0);
    idle(2);
    chk("t6_two_sent", pop_cnt[0], 2);
    cyc(4'b0001, 3'b001, 1'b0, 1'b1);
    chk("t6_busy", busy, 0);
    chk("t6_cs", cs, 3'b000);
    chk("t6_valid", n_valid, 0);
    chk("t6_flit", n_flit, 0);
    chk("t6_co", co_cnt, 0);
    chk("t6_credit", m_credit, 4);
    idle(2);
    chk("t6_no_more_pops", pop_cnt[0], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
